// File: rtl/multi_freq_gen.sv
// multi_freq_gen: bank of CHANNELS independent programmable clock generators.
// Each channel produces a waveform that is high for cfg_high clk cycles and
// low for cfg_low clk cycles, optionally delayed by cfg_phase after a start.
// A common start pulse phase-aligns all configured channels, and 'locked'
// reports once every configured channel has run LOCK_PERIODS full periods.
module multi_freq_gen #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 16,
  parameter int LOCK_PERIODS = 3,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PER_W       = (LOCK_PERIODS > 0) ? $clog2(LOCK_PERIODS + 1) : 1
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          PWRDWN,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic [CNT_W-1:0]              cfg_high,
  input  logic [CNT_W-1:0]              cfg_low,
  input  logic [CNT_W-1:0]              cfg_phase,
  input  logic                          start,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS*(CNT_W+1)-1:0] out_period,
  output logic                          locked
);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_HIGH, S_LOW} state_e;

  state_e              state_q     [CHANNELS];
  state_e              state_d     [CHANNELS];
  logic [CNT_W-1:0]    cnt_q       [CHANNELS];
  logic [CNT_W-1:0]    cnt_d       [CHANNELS];
  logic [CNT_W-1:0]    actHigh_q   [CHANNELS];
  logic [CNT_W-1:0]    actHigh_d   [CHANNELS];
  logic [CNT_W-1:0]    actLow_q    [CHANNELS];
  logic [CNT_W-1:0]    actLow_d    [CHANNELS];
  logic [CNT_W-1:0]    actPhase_q  [CHANNELS];
  logic [CNT_W-1:0]    actPhase_d  [CHANNELS];
  logic [CNT_W-1:0]    pendHigh_q  [CHANNELS];
  logic [CNT_W-1:0]    pendHigh_d  [CHANNELS];
  logic [CNT_W-1:0]    pendLow_q   [CHANNELS];
  logic [CNT_W-1:0]    pendLow_d   [CHANNELS];
  logic [CNT_W-1:0]    pendPhase_q [CHANNELS];
  logic [CNT_W-1:0]    pendPhase_d [CHANNELS];
  logic [PER_W-1:0]    per_q       [CHANNELS];
  logic [PER_W-1:0]    per_d       [CHANNELS];
  logic [CNT_W:0]      period_q    [CHANNELS];
  logic [CNT_W:0]      period_d    [CHANNELS];

  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] applied;
  logic [CHANNELS-1:0] wrHit;

  logic                armed_q;
  logic                armed_d;
  logic                locked_q;
  logic                locked_d;
  logic                chInRange;
  logic                wrAcc;
  logic                anyCfg;
  logic                allDone;
  logic [CNT_W-1:0]    effHigh;
  logic [CNT_W-1:0]    effLow;
  logic [CNT_W-1:0]    effPhase;

  // Write handshake: a channel with an outstanding pending config refuses new writes.
  always_comb begin
    chInRange = (32'(cfg_ch) < CHANNELS);
    cfg_ready = 1'b0;
    if (!RST && !PWRDWN) begin
      if (!chInRange) begin
        cfg_ready = 1'b1;
      end else begin
        cfg_ready = ~pend_q[cfg_ch];
      end
    end
    wrAcc = cfg_valid & cfg_ready & chInRange;
    for (int i = 0; i < CHANNELS; i++) begin
      wrHit[i] = wrAcc && (32'(cfg_ch) == i);
    end
  end

  // Per-channel next state: power-down, start/restart, config capture and waveform sequencing.
  always_comb begin
    effHigh  = '0;
    effLow   = '0;
    effPhase = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      actHigh_d[i]   = actHigh_q[i];
      actLow_d[i]    = actLow_q[i];
      actPhase_d[i]  = actPhase_q[i];
      pendHigh_d[i]  = pendHigh_q[i];
      pendLow_d[i]   = pendLow_q[i];
      pendPhase_d[i] = pendPhase_q[i];
      pend_d[i]      = pend_q[i];
      per_d[i]       = per_q[i];
      out_d[i]       = out_q[i];
      applied[i]     = 1'b0;
      effHigh        = actHigh_q[i];
      effLow         = actLow_q[i];
      effPhase       = actPhase_q[i];

      if (PWRDWN) begin
        state_d[i] = S_IDLE;
        out_d[i]   = 1'b0;
      end else if (start) begin
        if (wrHit[i]) begin
          effHigh  = cfg_high;
          effLow   = cfg_low;
          effPhase = cfg_phase;
        end else if (pend_q[i]) begin
          effHigh  = pendHigh_q[i];
          effLow   = pendLow_q[i];
          effPhase = pendPhase_q[i];
        end
        applied[i]    = wrHit[i] | pend_q[i];
        actHigh_d[i]  = effHigh;
        actLow_d[i]   = effLow;
        actPhase_d[i] = effPhase;
        pend_d[i]     = 1'b0;
        per_d[i]      = '0;
        if (effHigh != '0 && effLow != '0) begin
          if (effPhase == '0) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = effHigh;
            out_d[i]   = 1'b1;
          end else begin
            state_d[i] = S_PHASE;
            cnt_d[i]   = effPhase;
            out_d[i]   = 1'b0;
          end
        end else begin
          state_d[i] = S_IDLE;
          out_d[i]   = 1'b0;
        end
      end else begin
        if (wrHit[i]) begin
          if (state_q[i] == S_IDLE) begin
            actHigh_d[i]  = cfg_high;
            actLow_d[i]   = cfg_low;
            actPhase_d[i] = cfg_phase;
            applied[i]    = 1'b1;
          end else begin
            pendHigh_d[i]  = cfg_high;
            pendLow_d[i]   = cfg_low;
            pendPhase_d[i] = cfg_phase;
            pend_d[i]      = 1'b1;
          end
        end
        case (state_q[i])
          S_IDLE: begin
            out_d[i] = 1'b0;
          end
          S_PHASE: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = S_HIGH;
              cnt_d[i]   = actHigh_q[i];
              out_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          S_HIGH: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = S_LOW;
              cnt_d[i]   = actLow_q[i];
              out_d[i]   = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          S_LOW: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              if (per_q[i] != PER_W'(LOCK_PERIODS)) begin
                per_d[i] = per_q[i] + PER_W'(1);
              end
              if (pend_q[i]) begin
                actHigh_d[i]  = pendHigh_q[i];
                actLow_d[i]   = pendLow_q[i];
                actPhase_d[i] = pendPhase_q[i];
                pend_d[i]     = 1'b0;
                applied[i]    = 1'b1;
              end
              if (actHigh_d[i] != '0 && actLow_d[i] != '0) begin
                state_d[i] = S_HIGH;
                cnt_d[i]   = actHigh_d[i];
                out_d[i]   = 1'b1;
              end else begin
                state_d[i] = S_IDLE;
                out_d[i]   = 1'b0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            out_d[i]   = 1'b0;
          end
        endcase
      end

      period_d[i] = {1'b0, actHigh_d[i]} + {1'b0, actLow_d[i]};
    end
  end

  // Lock tracking: armed by start, disarmed by any config change, satisfied when all configured channels are mature.
  always_comb begin
    armed_d = armed_q;
    if (PWRDWN) begin
      armed_d = 1'b0;
    end else if (start) begin
      armed_d = 1'b1;
    end else if (|applied) begin
      armed_d = 1'b0;
    end
    anyCfg  = 1'b0;
    allDone = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (actHigh_d[i] != '0 && actLow_d[i] != '0) begin
        anyCfg = 1'b1;
        if (per_d[i] != PER_W'(LOCK_PERIODS)) begin
          allDone = 1'b0;
        end
      end
    end
    locked_d = armed_d & anyCfg & allDone;
  end

  // State registers with synchronous reset clearing every config, FSM and output.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]     <= S_IDLE;
        cnt_q[i]       <= '0;
        actHigh_q[i]   <= '0;
        actLow_q[i]    <= '0;
        actPhase_q[i]  <= '0;
        pendHigh_q[i]  <= '0;
        pendLow_q[i]   <= '0;
        pendPhase_q[i] <= '0;
        per_q[i]       <= '0;
        period_q[i]    <= '0;
      end
      pend_q   <= '0;
      out_q    <= '0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        actHigh_q[i]   <= actHigh_d[i];
        actLow_q[i]    <= actLow_d[i];
        actPhase_q[i]  <= actPhase_d[i];
        pendHigh_q[i]  <= pendHigh_d[i];
        pendLow_q[i]   <= pendLow_d[i];
        pendPhase_q[i] <= pendPhase_d[i];
        per_q[i]       <= per_d[i];
        period_q[i]    <= period_d[i];
      end
      pend_q   <= pend_d;
      out_q    <= out_d;
      armed_q  <= armed_d;
      locked_q <= locked_d;
    end
  end

  // Power-down gates the visible outputs immediately, not just from the next edge.
  assign out    = out_q & {CHANNELS{~PWRDWN}};
  assign locked = locked_q & ~PWRDWN;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_period
    assign out_period[g*(CNT_W+1) +: CNT_W+1] = period_q[g];
  end

endmodule

// File: tb/tb_multi_freq_gen.sv
// tb_multi_freq_gen: directed and random stimulus for multi_freq_gen, checked
// against a timeline model that derives each output from the edge at which the
// current waveform segment first went high.
module tb_multi_freq_gen;

  localparam int CH    = 4;
  localparam int CW    = 16;
  localparam int LOCKP = 3;

  logic                  clk = 1'b0;
  logic                  RST = 1'b0;
  logic                  PWRDWN = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [1:0]            cfg_ch = '0;
  logic [CW-1:0]         cfg_high = '0;
  logic [CW-1:0]         cfg_low = '0;
  logic [CW-1:0]         cfg_phase = '0;
  logic                  start = 1'b0;
  logic [CH-1:0]         out;
  logic [CH*(CW+1)-1:0]  out_period;
  logic                  locked;

  int checks = 0;
  int errors = 0;

  // Reference model: active/pending configs, whether the channel runs, and the
  // edge index at which the current segment's first high cycle begins.
  int mH[CH], mL[CH], mP[CH];
  int pH[CH], pL[CH], pP[CH];
  int mSeg0[CH];
  bit mPend[CH], mRun[CH];
  bit mArmed;
  int cyc;

  multi_freq_gen #(.CHANNELS(CH), .CNT_W(CW), .LOCK_PERIODS(LOCKP)) dut (
    .clk       (clk),
    .RST       (RST),
    .PWRDWN    (PWRDWN),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_phase (cfg_phase),
    .start     (start),
    .out       (out),
    .out_period(out_period),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] modelOut();
    logic [CH-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      if (mRun[i] && cyc >= mSeg0[i]) v[i] = ((cyc - mSeg0[i]) % (mH[i] + mL[i])) < mH[i];
    end
    return v;
  endfunction

  function automatic logic modelLocked();
    bit anyCfg;
    bit allDone;
    anyCfg  = 1'b0;
    allDone = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (mH[i] != 0 && mL[i] != 0) begin
        anyCfg = 1'b1;
        if (!(mRun[i] && cyc >= mSeg0[i] && (cyc - mSeg0[i]) / (mH[i] + mL[i]) >= LOCKP)) allDone = 1'b0;
      end
    end
    return mArmed && anyCfg && allDone;
  endfunction

  task automatic modelEdge(input bit rst, pd, st, acc, input int ch, h, l, p);
    int eh, el, ep;
    cyc++;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        mH[i] = 0; mL[i] = 0; mP[i] = 0; pH[i] = 0; pL[i] = 0; pP[i] = 0;
        mPend[i] = 0; mRun[i] = 0; mSeg0[i] = 0;
      end
      mArmed = 0;
      return;
    end
    if (pd) begin
      for (int i = 0; i < CH; i++) mRun[i] = 0;
      mArmed = 0;
      return;
    end
    if (st) begin
      for (int i = 0; i < CH; i++) begin
        if (acc && ch == i) begin eh = h; el = l; ep = p; end
        else if (mPend[i]) begin eh = pH[i]; el = pL[i]; ep = pP[i]; end
        else begin eh = mH[i]; el = mL[i]; ep = mP[i]; end
        mH[i] = eh; mL[i] = el; mP[i] = ep; mPend[i] = 0;
        mRun[i] = (eh != 0 && el != 0);
        mSeg0[i] = cyc + ep;
      end
      mArmed = 1;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      if (mRun[i] && mPend[i] && cyc > mSeg0[i] && (cyc - mSeg0[i]) % (mH[i] + mL[i]) == 0) begin
        mH[i] = pH[i]; mL[i] = pL[i]; mP[i] = pP[i]; mPend[i] = 0; mArmed = 0;
        mRun[i] = (mH[i] != 0 && mL[i] != 0);
        mSeg0[i] = cyc;
      end
    end
    if (acc) begin
      if (!mRun[ch]) begin
        mH[ch] = h; mL[ch] = l; mP[ch] = p; mArmed = 0;
      end else begin
        pH[ch] = h; pL[ch] = l; pP[ch] = p; mPend[ch] = 1;
      end
    end
  endtask

  task automatic checkOutput();
    check("out", 32'(out), 32'(modelOut()));
    for (int i = 0; i < CH; i++) begin
      check($sformatf("out_period%0d", i), 32'(out_period[i*(CW+1) +: CW+1]), 32'(mH[i] + mL[i]));
    end
    check("locked", 32'(locked), 32'(modelLocked()));
  endtask

  // One clock step: drive at the falling edge, check the handshake, let the
  // rising edge happen, then compare the registered outputs against the model.
  task automatic applyStimulus(input bit rst, pd, st, v, input int ch, h, l, p);
    bit expReady;
    RST = rst; PWRDWN = pd; start = st; cfg_valid = v;
    cfg_ch = 2'(ch); cfg_high = CW'(h); cfg_low = CW'(l); cfg_phase = CW'(p);
    #1;
    expReady = !rst && !pd && !mPend[ch];
    check("cfg_ready", 32'(cfg_ready), 32'(expReady));
    @(posedge clk);
    modelEdge(rst, pd, st, v && expReady, ch, h, l, p);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    @(negedge clk);
    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 2, 3, 0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);

    $display("[TB] ch0 2/3 waveform and lock");
    applyStimulus(0, 0, 0, 1, 0, 2, 3, 0);
    check("r031_period0", 32'(out_period[CW:0]), 32'd5);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    check("r031_k0", 32'(out[0]), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      idle();
      check("r031_pattern", 32'(out[0]), 32'((k % 5) < 2));
      if (k == 14) check("r031_unlocked", 32'(locked), 32'd0);
      if (k == 15) check("r031_locked", 32'(locked), 32'd1);
    end

    $display("[TB] reconfigure running ch0 to 4/4");
    applyStimulus(0, 0, 0, 1, 0, 4, 4, 0);
    for (int k = 18; k <= 30; k++) begin
      idle();
      if (k == 19) check("r033_old_low", 32'(out[0]), 32'd0);
      if (k == 20) check("r033_new_high", 32'(out[0]), 32'd1);
      if (k == 20) check("r033_lock_clear", 32'(locked), 32'd0);
      if (k == 24) check("r033_new_low", 32'(out[0]), 32'd0);
    end

    $display("[TB] two channels with phase offset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 4, 4, 2);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    check("r032_k0", 32'(out[1:0]), 32'b01);
    for (int k = 1; k <= 30; k++) begin
      idle();
      if (k == 1) check("r032_k1", 32'(out[1:0]), 32'b00);
      if (k == 2) check("r032_k2", 32'(out[1:0]), 32'b11);
      if (k == 25) check("r032_unlocked", 32'(locked), 32'd0);
      if (k == 26) check("r032_locked", 32'(locked), 32'd1);
    end

    $display("[TB] zero high count to running ch1");
    applyStimulus(0, 0, 0, 1, 1, 0, 4, 0);
    for (int k = 0; k < 12; k++) idle();
    check("r036_ch1_idle", 32'(out[1]), 32'd0);
    check("r036_lock_clear", 32'(locked), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) idle();
    check("r036_relock", 32'(locked), 32'd1);

    $display("[TB] reset while high");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check("r034_out", 32'(out), 32'd0);
    check("r034_period0", 32'(out_period[CW:0]), 32'd0);
    idle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) idle();
    check("r034_noconf_out", 32'(out), 32'd0);
    check("r034_noconf_locked", 32'(locked), 32'd0);

    $display("[TB] power-down");
    applyStimulus(0, 0, 0, 1, 2, 3, 2, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) idle();
    check("r035_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      check("r035_pd_out", 32'(out), 32'd0);
      check("r035_pd_locked", 32'(locked), 32'd0);
    end
    for (int k = 0; k < 5; k++) idle();
    check("r035_wait_out", 32'(out), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    check("r035_phase_k0", 32'(out[2]), 32'd0);
    idle();
    check("r035_phase_k1", 32'(out[2]), 32'd1);
    for (int k = 0; k < 8; k++) idle();

    $display("[TB] config and start on the same edge");
    applyStimulus(0, 0, 1, 1, 3, 2, 2, 1);
    check("r026_k0", 32'(out[3]), 32'd0);
    check("r026_period3", 32'(out_period[3*(CW+1) +: CW+1]), 32'd4);
    idle();
    check("r026_k1", 32'(out[3]), 32'd1);
    for (int k = 0; k < 6; k++) idle();

    $display("[TB] random traffic");
    begin
      bit pdOn;
      bit r, st, v;
      int ch, h, l, p;
      pdOn = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 79) == 0) pdOn = !pdOn;
        r  = ($urandom_range(0, 99) == 0);
        st = ($urandom_range(0, 39) == 0);
        v  = ($urandom_range(0, 2) == 0);
        ch = int'($urandom_range(0, CH - 1));
        h  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
        l  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
        p  = int'($urandom_range(0, 3));
        applyStimulus(r, pdOn, st, v, ch, h, l, p);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_freq_gen.md
MULTI_FREQ_GEN -- requirements
Module: multi_freq_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent output clocks.
REQ-002 Parameter CNT_W, default 16: width of the high, low and phase count fields.
REQ-003 Parameter LOCK_PERIODS, default 3: full output periods per channel before lock is reported.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 PWRDWN  input  1  power-down: outputs forced low, all state held.
REQ-007 cfg_valid  input  1  config write request.
REQ-008 cfg_ready  output  1  config write accepted when cfg_valid and cfg_ready are both high on a clk edge.
REQ-009 cfg_ch  input  max(1,$clog2(CHANNELS))  target channel index.
REQ-010 cfg_high, cfg_low, cfg_phase  input  CNT_W each  high-phase clk count, low-phase clk count, start delay in clk counts.
REQ-011 start  input  1  single-cycle pulse that phase-aligns and restarts all configured channels.
REQ-012 out  output  CHANNELS  generated clocks; bit i belongs to channel i.
REQ-013 out_period  output  CHANNELS*(CNT_W+1)  per channel, active cfg_high+cfg_low; slice i = [i*(CNT_W+1) +: CNT_W+1].
REQ-014 locked  output  1  all configured channels are stable.

Function
REQ-015 Each channel SHALL hold active config (high, low, phase), a pending config with a pending flag, and FSM states IDLE, PHASE, HIGH, LOW.
REQ-016 A channel is "configured" when its active high and low counts are both non-zero; otherwise it SHALL stay in IDLE with out low.
REQ-017 cfg_ready SHALL be high iff RST=0, PWRDWN=0 and the pending flag of channel cfg_ch is clear; for cfg_ch >= CHANNELS it is high and the write is discarded.
REQ-018 An accepted write to an IDLE channel SHALL update its active config on the same edge; a write to a running channel SHALL set pending, and pending SHALL move to active at the LOW->HIGH boundary.
REQ-019 On a start edge, every configured channel SHALL enter PHASE with count cfg_phase, or HIGH directly if cfg_phase=0; pending configs are applied first.
REQ-020 HIGH SHALL last exactly cfg_high cycles with out=1; LOW SHALL last exactly cfg_low cycles with out=0; LOW then returns to HIGH.
REQ-021 With phase 0, out SHALL first be high in the cycle after the start edge; with phase P, P cycles later.
REQ-022 A start while running SHALL restart all channels, re-aligning their rising edges; cfg_phase is used only at start.
REQ-023 If an applied config has a zero count, that channel SHALL return to IDLE with out low.
REQ-024 locked SHALL assert when every configured channel has completed LOCK_PERIODS full HIGH+LOW periods since the last start; it stays 0 if no channel is configured.
REQ-025 locked SHALL clear on the edge of start, any config application, RST, or PWRDWN.
REQ-026 If a config is accepted and start is pulsed on the same edge, the new config SHALL be used by that start.
REQ-027 out_period SHALL use CNT_W+1 bits so the sum never wraps; the per-period cycle count SHALL be exactly cfg_high+cfg_low.

Reset
REQ-028 When RST=1 on an edge: all FSMs go to IDLE, all configs and pending flags clear, and out, out_period and locked go to 0; cfg_ready is 0 while RST=1.
REQ-029 RST SHALL have priority over PWRDWN, start and config writes.
REQ-030 While PWRDWN=1, out SHALL be 0 and locked SHALL be 0, with counters and configs frozen; after PWRDWN falls, channels SHALL wait for start.

Verification
REQ-031 Write ch0 high=2 low=3 phase=0, then pulse start -> out[0] is 1,1,0,0,0 repeating, starting the cycle after start; out_period slice 0 = 5.
REQ-032 Write ch0 high=1 low=1 phase=0 and ch1 high=4 low=4 phase=2, then start -> out[1] rises 2 cycles after out[0]; locked asserts after ch1 finishes its 3rd period (cycle 2+24 after start).
REQ-033 While ch0 runs with 2/3, write 4/4 -> cfg_ready for ch0 drops; the current period completes as 2/3, 4/4 begins at the next rising edge, and locked clears.
REQ-034 Apply RST mid-HIGH -> next cycle all outputs are 0 and cfg_ready returns to 1; a later start with no config keeps out=0 and locked=0.
REQ-035 Assert PWRDWN for 10 cycles during operation -> out=0 and locked=0 throughout; after it falls, outputs stay low until start, and a start then resumes with the held config.
REQ-036 Write high=0 to a running channel -> at the period boundary the channel goes IDLE with out=0; locked re-evaluates over the remaining channels after the next start.
